// File: rtl/cam_pkg.sv
// Shared types and constants for the camera-bus transmitter.
// Holds the FSM state type, byte ordering, RGB565 field widths and the
// built-in test-pattern generator.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } cam_state_t;

  localparam logic BYTE_HI_FIRST = 1'b1;

  localparam int unsigned R_W     = 5;
  localparam int unsigned G_W     = 6;
  localparam int unsigned B_W     = 5;
  localparam int unsigned PIX_W   = R_W + G_W + B_W;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned DATA_W  = 8;

  // Test pattern: red from the line index, green and blue from the column.
  function automatic logic [PIX_W-1:0] test_pixel(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {y[R_W-1:0], x[G_W-1:0], x[B_W-1:0]};
  endfunction

endpackage

// File: rtl/cam_stream_tx_if.sv
// Pixel-source fetch bus plus camera parallel bus of the transmitter.
// master: the transmitter (drives fetch requests and camera outputs).
// slave : the pixel source / capture side.
interface cam_stream_tx_if;
  import cam_pkg::*;

  logic                 pix_rd;
  logic [COORD_W-1:0]   pix_x;
  logic [COORD_W-1:0]   pix_y;
  logic [PIX_W-1:0]     pix_data;
  logic                 pclk;
  logic                 vsync;
  logic                 href;
  logic [DATA_W-1:0]    data;
  logic                 frame_start;
  logic                 frame_done;

  modport master (
    output pix_rd, pix_x, pix_y, pclk, vsync, href, data, frame_start, frame_done,
    input  pix_data
  );

  modport slave (
    input  pix_rd, pix_x, pix_y, pclk, vsync, href, data, frame_start, frame_done,
    output pix_data
  );

endinterface

// File: rtl/cam_pclk_div.sv
// Pixel clock divider: pclk toggles every PCLK_DIV clk cycles.
// Ports: clk, rst_n in; pclk (registered), rise_c / fall_c (combinational
// strobes, high on the clk cycle whose edge makes pclk rise / fall).
module cam_pclk_div #(
  parameter int unsigned PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tc_c;

  assign tc_c   = (cnt == CNT_W'(PCLK_DIV - 1));
  assign rise_c = tc_c & ~pclk;
  assign fall_c = tc_c &  pclk;

  // Free-running half-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pclk <= 1'b0;
    end else if (tc_c) begin
      cnt  <= '0;
      pclk <= ~pclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cam_stream_tx.sv
// Camera-side transmitter: sensor-style frame timing, RGB565 pixels sent
// as two bytes (high first) on an 8-bit bus, pixels from an external
// one-cycle-latency source or an internal test pattern.
// Ports: clk, rst_n, enable (frame request), pattern_sel (pixel source),
// bus (master side: fetch strobe/coords/data, pclk/vsync/href/data,
// frame_start/frame_done pulses).
module cam_stream_tx
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned PCLK_DIV    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           pattern_sel,
  cam_stream_tx_if.master bus
);

  localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned TOTAL_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned ACT_START   = VSYNC_LINES + V_BACK;
  localparam int unsigned ACT_END     = ACT_START + V_ACTIVE;
  localparam int unsigned BYTE_W      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned LINE_W      = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;

  cam_state_t          state, state_nxt;
  logic [LINE_W-1:0]   line_cnt, line_nxt;
  logic [BYTE_W-1:0]   byte_cnt, byte_nxt;
  logic                href_nxt, fetch_c, frame_end_c;
  logic [DATA_W-1:0]   data_nxt;

  logic                pclk, rise_c, fall_c;
  logic                vsync, href, pix_rd, frame_start, frame_done, pat_q;
  logic [DATA_W-1:0]   data;
  logic [COORD_W-1:0]  pix_x, pix_y;
  logic [PIX_W-1:0]    pix_q;

  cam_pclk_div #(.PCLK_DIV(PCLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pclk   (pclk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Position and state for the pclk period that the next fall starts.
  // Evaluated at the preceding rise too, which is when the fetch is issued.
  always_comb begin
    state_nxt   = state;
    line_nxt    = line_cnt;
    byte_nxt    = byte_cnt;
    frame_end_c = 1'b0;
    if (state == ST_IDLE) begin
      line_nxt = '0;
      byte_nxt = '0;
      if (enable) state_nxt = ST_VSYNC;
    end else if (byte_cnt == BYTE_W'(LINE_LEN - 1)) begin
      byte_nxt = '0;
      if (line_cnt == LINE_W'(TOTAL_LINES - 1)) begin
        // The fall ending the frame restarts straight into vsync when enabled.
        frame_end_c = 1'b1;
        line_nxt    = '0;
        state_nxt   = enable ? ST_VSYNC : ST_IDLE;
      end else begin
        line_nxt = line_cnt + LINE_W'(1);
        case (state)
          ST_VSYNC:  if (line_nxt == LINE_W'(VSYNC_LINES)) state_nxt = ST_VBACK;
          ST_VBACK:  if (line_nxt == LINE_W'(ACT_START))   state_nxt = ST_ACTIVE;
          ST_ACTIVE: if (line_nxt == LINE_W'(ACT_END))     state_nxt = ST_VFRONT;
          default:   state_nxt = state;
        endcase
      end
    end else begin
      byte_nxt = byte_cnt + BYTE_W'(1);
    end
    href_nxt = (state_nxt == ST_ACTIVE) && (byte_nxt < BYTE_W'(2 * H_ACTIVE));
    fetch_c  = href_nxt && (byte_nxt[0] == 1'b0);
    data_nxt = 8'h00;
    if (href_nxt) data_nxt = (byte_nxt[0] ^ BYTE_HI_FIRST) ? pix_q[15:8] : pix_q[7:0];
  end

  // State, counters, fetch and serialiser; camera outputs move on pclk falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      line_cnt    <= '0;
      byte_cnt    <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= '0;
      pix_rd      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_q       <= '0;
      pat_q       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pix_rd      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (pix_rd) pix_q <= pat_q ? test_pixel(pix_x, pix_y) : bus.pix_data;
      if (rise_c && fetch_c) begin
        pix_rd <= 1'b1;
        pix_x  <= COORD_W'(byte_nxt >> 1);
        pix_y  <= COORD_W'(line_nxt - LINE_W'(ACT_START));
      end
      if (fall_c) begin
        state      <= state_nxt;
        line_cnt   <= line_nxt;
        byte_cnt   <= byte_nxt;
        vsync      <= (state_nxt == ST_VSYNC);
        href       <= href_nxt;
        data       <= data_nxt;
        frame_done <= frame_end_c;
        if (state_nxt == ST_VSYNC && (state == ST_IDLE || frame_end_c)) begin
          frame_start <= 1'b1;
          pat_q       <= pattern_sel;
        end
      end
    end
  end

  assign bus.pclk        = pclk;
  assign bus.vsync       = vsync;
  assign bus.href        = href;
  assign bus.data        = data;
  assign bus.pix_rd      = pix_rd;
  assign bus.pix_x       = pix_x;
  assign bus.pix_y       = pix_y;
  assign bus.frame_start = frame_start;
  assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_cam_stream_tx.sv
// Bench for cam_stream_tx with a small frame geometry; every frame is
// compared period by period against an arithmetic model of the frame.
module tb_cam_stream_tx;
  import cam_pkg::*;

  localparam int HA = 4, VA = 2, HB = 4, VSL = 1, VB = 1, VF = 1, DIV = 2;
  localparam int LINE_LEN = 2 * HA + HB;
  localparam int TOT      = VSL + VB + VA + VF;
  localparam int FRAME_P  = TOT * LINE_LEN;
  localparam int PER      = 2 * DIV;
  localparam int BUDGET   = 4 * FRAME_P * PER;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pattern_sel = 1'b0;
  int   checks = 0, errors = 0;

  cam_stream_tx_if bus();

  cam_stream_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VSL),
    .V_BACK(VB), .V_FRONT(VF), .PCLK_DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel), .bus(bus)
  );

  always #5 clk = ~clk;

  // External pixel source: answers a read on the next clk, junk otherwise.
  logic [15:0] mem [0:VA-1][0:HA-1];
  always @(negedge clk) begin
    if (bus.pix_rd && int'(bus.pix_y) < VA && int'(bus.pix_x) < HA)
      bus.pix_data = mem[int'(bus.pix_y)][int'(bus.pix_x)];
    else
      bus.pix_data = 16'($urandom);
  end

  // Monitor: timestamps events, samples the bus at every pclk rise and fall.
  int         cyc = 0;
  logic       pclk_prev = 1'b0;
  int         fs_q[$], fd_q[$], rd_cyc[$], rd_x[$], rd_y[$];
  int         rise_cyc[$], fall_cyc[$];
  logic       rise_vs[$], rise_hr[$];
  logic [7:0] rise_dt[$], fall_dt[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.frame_start) fs_q.push_back(cyc);
    if (bus.frame_done)  fd_q.push_back(cyc);
    if (bus.pix_rd) begin
      rd_cyc.push_back(cyc);
      rd_x.push_back(int'(bus.pix_x));
      rd_y.push_back(int'(bus.pix_y));
    end
    if (bus.pclk && !pclk_prev) begin
      rise_cyc.push_back(cyc);
      rise_vs.push_back(bus.vsync);
      rise_hr.push_back(bus.href);
      rise_dt.push_back(bus.data);
    end
    if (!bus.pclk && pclk_prev) begin
      fall_cyc.push_back(cyc);
      fall_dt.push_back(bus.data);
    end
    pclk_prev = bus.pclk;
  end

  task automatic mon_clear();
    fs_q.delete(); fd_q.delete(); rd_cyc.delete(); rd_x.delete(); rd_y.delete();
    rise_cyc.delete(); rise_vs.delete(); rise_hr.delete(); rise_dt.delete();
    fall_cyc.delete(); fall_dt.delete();
  endtask

  // Expected bus contents for pclk period p of a frame (p=0 starts at the vsync rise).
  function automatic void model(input int p, input bit pat, output logic vs,
                                output logic hr, output logic [7:0] dt);
    int line, b, x, y;
    logic [15:0] pix;
    line = p / LINE_LEN;
    b    = p % LINE_LEN;
    vs   = (line < VSL);
    hr   = (line >= VSL + VB) && (line < VSL + VB + VA) && (b < 2 * HA);
    dt   = 8'h00;
    if (hr) begin
      y   = line - VSL - VB;
      x   = b / 2;
      pix = pat ? 16'(((y % 32) << 11) + ((x % 64) << 5) + (x % 32)) : mem[y][x];
      dt  = (b % 2 == 0) ? pix[15:8] : pix[7:0];
    end
  endfunction

  task automatic wait_start(input string tag, output int fs);
    int n = 0;
    fs = -1;
    while (!bus.frame_start && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!bus.frame_start) begin
      errors++;
      $display("FAIL %s frame_start timeout: got none, want one within %0d clk", tag, BUDGET);
    end else fs = cyc + 1;
  endtask

  task automatic wait_done(input string tag, input int count);
    int n = 0;
    while (fd_q.size() < count && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (fd_q.size() < count) begin
      errors++;
      $display("FAIL %s frame_done timeout: got %0d pulses, want %0d", tag, fd_q.size(), count);
    end
  endtask

  task automatic wait_href(input string tag);
    int n = 0;
    while (!bus.href && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!bus.href) begin
      errors++;
      $display("FAIL %s href timeout: got href=0, want 1 within %0d clk", tag, BUDGET);
    end
  endtask

  // Whole-frame comparison plus the frame-level timing properties.
  task automatic check_frame(input int fs, input bit pat, input string tag);
    int p = 0, vs_cnt = 0, hr_runs = 0, hr_len = 0, bad_len = 0, fd_at = -1;
    logic vs, hr, hr_prev;
    logic [7:0] dt;
    hr_prev = 1'b0;
    for (int k = 0; k < rise_cyc.size(); k++) begin
      if (rise_cyc[k] > fs && p < FRAME_P) begin
        model(p, pat, vs, hr, dt);
        checks++;
        if ({rise_vs[k], rise_hr[k], rise_dt[k]} !== {vs, hr, dt}) begin
          errors++;
          $display("FAIL %s period %0d: got vs=%b href=%b data=%h, want vs=%b href=%b data=%h",
                   tag, p, rise_vs[k], rise_hr[k], rise_dt[k], vs, hr, dt);
        end
        if (rise_vs[k]) vs_cnt++;
        if (rise_hr[k]) begin
          if (!hr_prev) hr_runs++;
          hr_len++;
        end else if (hr_prev) begin
          if (hr_len != 2 * HA) bad_len++;
          hr_len = 0;
        end
        hr_prev = rise_hr[k];
        p++;
      end
    end
    checks++;
    if (p != FRAME_P) begin
      errors++; $display("FAIL %s periods seen: got %0d, want %0d", tag, p, FRAME_P);
    end
    checks++;
    if (vs_cnt != VSL * LINE_LEN) begin
      errors++; $display("FAIL %s vsync periods: got %0d, want %0d", tag, vs_cnt, VSL * LINE_LEN);
    end
    checks++;
    if (hr_runs != VA || bad_len != 0) begin
      errors++;
      $display("FAIL %s href pulses: got %0d (%0d wrong length), want %0d of %0d", tag,
               hr_runs, bad_len, VA, 2 * HA);
    end
    foreach (fd_q[i]) if (fd_at < 0 && fd_q[i] > fs) fd_at = fd_q[i];
    checks++;
    if (fd_at - fs != FRAME_P * PER) begin
      errors++;
      $display("FAIL %s frame_done offset: got %0d clk, want %0d", tag, fd_at - fs, FRAME_P * PER);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bus.pclk, bus.vsync, bus.href, bus.data, bus.pix_rd, bus.pix_x, bus.pix_y,
         bus.frame_start, bus.frame_done} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got pclk=%b vs=%b href=%b data=%h rd=%b x=%0d y=%0d fs=%b fd=%b, want all 0",
               tag, bus.pclk, bus.vsync, bus.href, bus.data, bus.pix_rd, bus.pix_x, bus.pix_y,
               bus.frame_start, bus.frame_done);
    end
  endtask

  task automatic test_reset();
    logic s [0:39];
    int bad_tog = 0, bad_out = 0;
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;
    mon_clear();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      s[i] = bus.pclk;
      if (bus.vsync || bus.href || bus.data != 8'h00) bad_out++;
      if (i >= 2 && s[i] !== ~s[i-2]) bad_tog++;
    end
    checks++;
    if (bad_tog != 0) begin
      errors++; $display("FAIL pclk_toggle: got %0d bad samples, want 0", bad_tog);
    end
    checks++;
    if (bad_out != 0 || fs_q.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active samples, %0d frame_starts, want 0 and 0",
               bad_out, fs_q.size());
    end
  endtask

  task automatic test_external();
    int fs, fa = -1, ra = -1, ir = -1;
    foreach (mem[y, x]) mem[y][x] = 16'($urandom);
    mem[0][0] = 16'hA5C3;
    @(posedge clk); #1;
    mon_clear();
    pattern_sel = 1'b0;
    enable = 1'b1;
    wait_start("ext", fs);
    enable = 1'b0;
    wait_done("ext", 1);
    repeat (4) @(posedge clk); #1;
    check_frame(fs, 1'b0, "ext");
    foreach (fall_cyc[i]) if (fall_cyc[i] == fs + (VSL + VB) * LINE_LEN * PER) fa = i;
    foreach (rise_cyc[i]) if (rise_cyc[i] == fs + ((VSL + VB) * LINE_LEN + 1) * PER + DIV) ra = i;
    checks++;
    if (fa < 0 || fall_dt[fa] !== 8'hA5) begin
      errors++; $display("FAIL ext_hi_byte: got %h, want a5", (fa < 0) ? 8'hxx : fall_dt[fa]);
    end
    checks++;
    if (ra < 0 || rise_dt[ra] !== 8'hC3) begin
      errors++; $display("FAIL ext_lo_byte: got %h, want c3", (ra < 0) ? 8'hxx : rise_dt[ra]);
    end
    if (fa >= 0) foreach (rd_cyc[i]) if (rd_cyc[i] == fall_cyc[fa] - DIV) ir = i;
    checks++;
    if (ir < 0 || rd_x[ir] != 0 || rd_y[ir] != 0) begin
      errors++;
      $display("FAIL ext_rd_latency: got no (0,0) read %0d clk before the a5 fall, want one", DIV);
    end
    checks++;
    if (rd_cyc.size() != HA * VA) begin
      errors++; $display("FAIL ext_rd_count: got %0d, want %0d", rd_cyc.size(), HA * VA);
    end
  endtask

  task automatic test_pattern();
    int fs, i0 = -1, i1 = -1;
    int p0 = (VSL + VB + 1) * LINE_LEN + 6;
    foreach (mem[y, x]) mem[y][x] = 16'($urandom);
    @(posedge clk); #1;
    mon_clear();
    pattern_sel = 1'b1;
    enable = 1'b1;
    wait_start("pat", fs);
    enable = 1'b0;
    pattern_sel = 1'b0;
    wait_done("pat", 1);
    repeat (4) @(posedge clk); #1;
    check_frame(fs, 1'b1, "pat");
    foreach (rise_cyc[i]) begin
      if (rise_cyc[i] == fs + p0 * PER + DIV) i0 = i;
      if (rise_cyc[i] == fs + (p0 + 1) * PER + DIV) i1 = i;
    end
    checks++;
    if (i0 < 0 || i1 < 0 || rise_dt[i0] !== 8'h08 || rise_dt[i1] !== 8'h63) begin
      errors++;
      $display("FAIL pat_y1_x3: got %h %h, want 08 63",
               (i0 < 0) ? 8'hxx : rise_dt[i0], (i1 < 0) ? 8'hxx : rise_dt[i1]);
    end
  endtask

  task automatic test_enable_drop();
    int fs, late_vs = 0;
    foreach (mem[y, x]) mem[y][x] = 16'($urandom);
    @(posedge clk); #1;
    mon_clear();
    pattern_sel = 1'($urandom);
    enable = 1'b1;
    wait_start("drop", fs);
    wait_href("drop");
    enable = 1'b0;
    wait_done("drop", 1);
    for (int i = 0; i < 2 * LINE_LEN * PER; i++) begin
      @(posedge clk); #1;
      if (bus.vsync) late_vs++;
    end
    check_frame(fs, pattern_sel, "drop");
    checks++;
    if (fs_q.size() != 1 || late_vs != 0) begin
      errors++;
      $display("FAIL drop_no_restart: got %0d frame_starts, %0d vsync clk after done, want 1 and 0",
               fs_q.size(), late_vs);
    end
  endtask

  task automatic test_back_to_back();
    int fs;
    foreach (mem[y, x]) mem[y][x] = 16'($urandom);
    @(posedge clk); #1;
    mon_clear();
    pattern_sel = 1'b0;
    enable = 1'b1;
    wait_start("b2b", fs);
    wait_done("b2b", 1);
    enable = 1'b0;
    wait_done("b2b", 2);
    repeat (4) @(posedge clk); #1;
    checks++;
    if (fs_q.size() != 2 || fs_q[1] != fd_q[0]) begin
      errors++;
      $display("FAIL b2b_restart: got %0d frame_starts, second at %0d, want 2 with second at %0d",
               fs_q.size(), (fs_q.size() > 1) ? fs_q[1] : -1, fd_q[0]);
    end
    check_frame(fs, 1'b0, "b2b_f0");
    if (fs_q.size() > 1) check_frame(fs_q[1], 1'b0, "b2b_f1");
  endtask

  task automatic test_reset_mid();
    int fs;
    @(posedge clk); #1;
    mon_clear();
    pattern_sel = 1'b1;
    enable = 1'b1;
    wait_start("rst", fs);
    wait_href("rst");
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_async");
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_clear();
    enable = 1'b1;
    wait_start("rst_restart", fs);
    enable = 1'b0;
    wait_done("rst_restart", 1);
    repeat (4) @(posedge clk); #1;
    check_frame(fs, 1'b1, "rst_restart");
  endtask

  initial begin
    test_reset();
    test_external();
    test_pattern();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
